// File: rtl/fpmul_ssm_norm_n23.sv
// Pack stage of the approximate FP32 multiplier. Classifies operands, adds exponents,
// then normalizes the segmented mantissa term, clamps and packs, with a 2-stage valid/ready pipeline.
module fpmul_ssm_norm_n23 #(
    parameter int unsigned BIAS      = 127,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [25:0] in_ris,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {ClsZero, ClsNorm, ClsInf, ClsNan} cls_e;

    function automatic cls_e classify(input logic [31:0] x);
        cls_e c;
        if (x[30:23] == 8'h00) begin
            c = ClsZero;
        end else if (x[30:23] == 8'hFF) begin
            c = (x[22:0] == 23'd0) ? ClsInf : ClsNan;
        end else begin
            c = ClsNorm;
        end
        return c;
    endfunction

    logic               s1_valid;
    logic               s1_sign;
    cls_e               s1_cls_a;
    cls_e               s1_cls_b;
    logic signed [9:0]  s1_esum;
    logic [25:0]        s1_ris;
    logic               s2_load;

    logic [9:0]         esum_c;
    logic               n;
    logic [25:0]        ris_m;
    logic [22:0]        frac;
    logic signed [10:0] e;
    logic               any_nan;
    logic               any_inf;
    logic               any_zero;
    logic [31:0]        p_d;
    logic [2:0]         flags_d;

    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;

    // Modulo-1024 arithmetic; the result range [-127, 383] fits the signed 10-bit field.
    assign esum_c = 10'(in_a[30:23]) + 10'(in_b[30:23]) - 10'(BIAS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls_a <= ClsZero;
            s1_cls_b <= ClsZero;
            s1_esum  <= '0;
            s1_ris   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= in_a[31] ^ in_b[31];
                s1_cls_a <= classify(in_a);
                s1_cls_b <= classify(in_b);
                s1_esum  <= esum_c;
                s1_ris   <= in_ris;
            end
        end
    end

    always_comb begin
        any_nan  = (s1_cls_a == ClsNan) || (s1_cls_b == ClsNan);
        any_inf  = (s1_cls_a == ClsInf) || (s1_cls_b == ClsInf);
        any_zero = (s1_cls_a == ClsZero) || (s1_cls_b == ClsZero);

        // Mantissa in [2,4) when ris >= 2^24: shift right one more and bump the exponent.
        n     = s1_ris[25] | s1_ris[24];
        ris_m = s1_ris - 26'h100_0000;
        frac  = n ? 23'(ris_m >> 2) : 23'(s1_ris >> 1);
        e     = {s1_esum[9], s1_esum} + {10'd0, n};

        p_d     = '0;
        flags_d = '0;
        if (any_nan || (any_inf && any_zero)) begin
            p_d     = CANON_NAN;
            flags_d = 3'b100;
        end else if (any_inf) begin
            p_d = {s1_sign, 8'hFF, 23'd0};
        end else if (any_zero) begin
            p_d = {s1_sign, 31'd0};
        end else if (e >= 11'sd255) begin
            p_d     = {s1_sign, 8'hFF, 23'd0};
            flags_d = 3'b010;
        end else if (e <= 11'sd0) begin
            p_d     = {s1_sign, 31'd0};
            flags_d = 3'b001;
        end else begin
            p_d = {s1_sign, e[7:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_flags <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_p     <= p_d;
            out_flags <= flags_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpmul_ssm_norm_n23.sv
// Bench for fpmul_ssm_norm_n23: directed vector table, stall/reset sequences, and a
// randomized stream checked against an arithmetic reference model.
module tb_fpmul_ssm_norm_n23;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [25:0] in_ris;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic [2:0]  out_flags;

    fpmul_ssm_norm_n23 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ris    (in_ris),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [25:0] ris;
        logic [31:0] p;
        logic [2:0]  flags;
    } vec_t;

    typedef struct {
        logic [31:0] p;
        logic [2:0]  flags;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: IEEE-style special-case rules, then value-level normalization of 1 + ris/2^24.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [25:0] ris);
        exp_t   r;
        int     ea = int'(a[30:23]);
        int     eb = int'(b[30:23]);
        bit     a_zero = (ea == 0);
        bit     b_zero = (eb == 0);
        bit     a_inf  = (ea == 255) && (a[22:0] == 0);
        bit     b_inf  = (eb == 255) && (b[22:0] == 0);
        bit     a_nan  = (ea == 255) && (a[22:0] != 0);
        bit     b_nan  = (eb == 255) && (b[22:0] != 0);
        logic   s = a[31] ^ b[31];
        longint sig = longint'(1) * 16777216 + longint'(ris);
        longint fr;
        int     e;
        r.flags = 3'b000;
        if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
            r.p = 32'h7FC00000;
            r.flags = 3'b100;
        end else if (a_inf || b_inf) begin
            r.p = {s, 31'h7F800000};
        end else if (a_zero || b_zero) begin
            r.p = {s, 31'd0};
        end else begin
            e = ea + eb - 127;
            if (sig >= 64'd33554432) begin
                e = e + 1;
                fr = (sig - 64'd33554432) / 4;
            end else begin
                fr = (sig - 64'd16777216) / 2;
            end
            if (e >= 255) begin
                r.p = {s, 31'h7F800000};
                r.flags = 3'b010;
            end else if (e <= 0) begin
                r.p = {s, 31'd0};
                r.flags = 3'b001;
            end else begin
                r.p = {s, 8'(e), 23'(fr)};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  ex;
        logic [22:0] fr = 23'($urandom);
        int          k  = int'($urandom_range(0, 9));
        case (k)
            0:       ex = 8'h00;
            1:       begin ex = 8'hFF; fr = 23'd0; end
            2:       begin ex = 8'hFF; fr = fr | 23'd1; end
            3:       ex = 8'($urandom_range(200, 254));
            4:       ex = 8'($urandom_range(1, 60));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), ex, fr};
    endfunction

    // Single op into an empty pipe with out_ready=1; checks 2-cycle latency and result.
    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_ris   = v.ris;
        #1;
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " valid@1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({name, " valid@2"}, 64'(out_valid), 64'd1);
        check({name, " p"}, 64'(out_p), 64'(v.p));
        check({name, " flags"}, 64'(out_flags), 64'(v.flags));
    endtask

    vec_t vecs[$];

    initial begin
        bit   accepted;
        bit   hold_prev;
        bit   saw_stall_block;
        logic [31:0] prev_p;
        logic [2:0]  prev_f;
        int   sent;
        int   got;
        exp_t ex;
        exp_t ob;

        vecs.push_back('{32'h3F800000, 32'h3F800000, 26'h0000000, 32'h3F800000, 3'b000});
        vecs.push_back('{32'h3FC00000, 32'h3FC00000, 26'h1400000, 32'h40100000, 3'b000});
        vecs.push_back('{32'h7F000000, 32'h7F000000, 26'h0000000, 32'h7F800000, 3'b010});
        vecs.push_back('{32'h00800000, 32'h00800000, 26'h0000000, 32'h00000000, 3'b001});
        vecs.push_back('{32'h7F800000, 32'h00000000, 26'h0000000, 32'h7FC00000, 3'b100});
        vecs.push_back('{32'hFF800000, 32'h3F800000, 26'h0000000, 32'hFF800000, 3'b000});
        vecs.push_back('{32'h80000000, 32'h3F800000, 26'h0000000, 32'h80000000, 3'b000});
        vecs.push_back('{32'h7F800001, 32'h3F800000, 26'h0000000, 32'h7FC00000, 3'b100});
        vecs.push_back('{32'h7F000000, 32'h3F800000, 26'h1000000, 32'h7F800000, 3'b010});
        vecs.push_back('{32'h7F000000, 32'h3F800000, 26'h0FFFFFF, 32'h7F7FFFFF, 3'b000});
        vecs.push_back('{32'h00800000, 32'h3F000000, 26'h0000000, 32'h00000000, 3'b001});
        vecs.push_back('{32'h00800000, 32'h3F000000, 26'h1000000, 32'h00800000, 3'b000});
        vecs.push_back('{32'hBF800000, 32'h3F800000, 26'h0000000, 32'hBF800000, 3'b000});
        vecs.push_back('{32'h00000001, 32'hBF800000, 26'h0000000, 32'h80000000, 3'b000});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ris    = '0;
        out_ready = 1'b1;
        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_p", 64'(out_p), 64'd0);
        check("reset out_flags", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stream 4 ops with a 3-cycle output stall in the middle.
        q.delete();
        sent = 0;
        got = 0;
        hold_prev = 1'b0;
        saw_stall_block = 1'b0;
        prev_p = '0;
        prev_f = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (hold_prev) begin
                check("stall hold p", 64'(out_p), 64'(prev_p));
                check("stall hold flags", 64'(out_flags), 64'(prev_f));
            end
            in_valid  = (sent < 4);
            in_a      = vecs[sent % 4].a;
            in_b      = vecs[sent % 4].b;
            in_ris    = vecs[sent % 4].ris;
            out_ready = !(cyc >= 2 && cyc < 5);
            #1;
            if (in_valid && !in_ready) saw_stall_block = 1'b1;
            if (in_valid && in_ready) begin
                q.push_back('{vecs[sent].p, vecs[sent].flags});
                sent++;
            end
            if (out_valid && out_ready) begin
                ex = q.pop_front();
                check($sformatf("stream res%0d p", got), 64'(out_p), 64'(ex.p));
                check($sformatf("stream res%0d flags", got), 64'(out_flags), 64'(ex.flags));
                got++;
            end
            hold_prev = out_valid && !out_ready;
            prev_p = out_p;
            prev_f = out_flags;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream delivered", 64'(got), 64'd4);
        check("stream in_ready dropped", 64'(saw_stall_block), 64'd1);
        #1;
        check("stream no duplicate", 64'(out_valid), 64'd0);

        // Two ops in flight, then an asynchronous reset pulse mid-cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_a = vecs[0].a; in_b = vecs[0].b; in_ris = vecs[0].ris;
        @(negedge clk);
        in_a = vecs[1].a; in_b = vecs[1].b; in_ris = vecs[1].ris;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre-reset out_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", 64'(out_valid), 64'd0);
        run_vec(vecs[1], "post-reset");

        // Randomized stream with random backpressure against the reference model.
        q.delete();
        sent = 0;
        got = 0;
        accepted = 1'b1;
        for (int cyc = 0; cyc < 5000 && (sent < 400 || q.size() != 0); cyc++) begin
            @(negedge clk);
            if (!in_valid || accepted) begin
                in_valid = (sent < 400) && ($urandom_range(0, 3) != 0);
                in_a     = rand_fp();
                in_b     = rand_fp();
                in_ris   = 26'($urandom_range(0, 3 * 16777216 - 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            accepted = in_valid && in_ready;
            if (accepted) begin
                q.push_back(ref_model(in_a, in_b, in_ris));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand spurious output", 64'(out_valid), 64'd0);
                end else begin
                    ex = q.pop_front();
                    ob.p = out_p;
                    ob.flags = out_flags;
                    check($sformatf("rand%0d p", got), 64'(ob.p), 64'(ex.p));
                    check($sformatf("rand%0d flags", got), 64'(ob.flags), 64'(ex.flags));
                    got++;
                end
            end
        end
        in_valid = 1'b0;
        check("rand all sent", 64'(sent), 64'd400);
        check("rand all delivered", 64'(got), 64'd400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
